// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (0) and load (1) writeback.
// Requesters may hold the port for multi-beat bursts; writes to R0 are dropped.
module regfile_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              Req0,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [DATA_W-1:0] Data0,
   input  logic              Last0,
   output logic              Gnt0,
   input  logic              Req1,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] Data1,
   input  logic              Last1,
   output logic              Gnt1,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic              Busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t              state;
   logic                prio;
   logic                acc;
   logic                acc_last;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_data;

   // Handshake: a beat transfers in any cycle where Reqx and Gntx are both high;
   // the requester holds Req/Addr/Data/Last stable until that cycle.
   // Grants depend only on state, Prio and Req, never on Last.
   always_comb begin
      Gnt0 = 1'b0;
      Gnt1 = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (Req0 && Req1) begin
                  Gnt0 = ~prio;
                  Gnt1 = prio;
               end else begin
                  Gnt0 = Req0;
                  Gnt1 = Req1;
               end
            end
            OWN0:    Gnt0 = Req0;
            OWN1:    Gnt1 = Req1;
            default: begin
               Gnt0 = 1'b0;
               Gnt1 = 1'b0;
            end
         endcase
      end
   end

   assign acc      = Gnt0 | Gnt1;
   assign acc_last = Gnt1 ? Last1 : Last0;
   assign acc_addr = Gnt1 ? Addr1 : Addr0;
   assign acc_data = Gnt1 ? Data1 : Data0;

   always_ff @(posedge Clk) begin
      if (reset) begin
         state     <= IDLE;
         prio      <= 1'b0;
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
      end else begin
         // R0 beats still complete the handshake but never reach the register file.
         if (acc && (acc_addr != '0)) begin
            RegWrite  <= 1'b1;
            WriteAddr <= acc_addr;
            WriteData <= acc_data;
         end else begin
            RegWrite  <= 1'b0;
         end

         if (acc) begin
            if (acc_last) begin
               state <= IDLE;
               prio  <= Gnt0;
            end else begin
               state <= Gnt0 ? OWN0 : OWN1;
            end
         end
      end
   end

   assign Busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single beats, round-robin,
// burst lockout with gaps, R0 suppression and reset mid-burst.
module tb_regfile_write_arbiter;

   logic        Clk = 1'b0;
   logic        reset;
   logic        Req0, Last0, Req1, Last1;
   logic [2:0]  Addr0, Addr1;
   logic [15:0] Data0, Data1;
   logic        Gnt0, Gnt1, RegWrite, Busy;
   logic [2:0]  WriteAddr;
   logic [15:0] WriteData;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
      .Clk(Clk), .reset(reset),
      .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Last0(Last0), .Gnt0(Gnt0),
      .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Last1(Last1), .Gnt1(Gnt1),
      .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
      .Busy(Busy), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input string tag, input logic rw, input logic [2:0] a, input logic [15:0] d);
      check({tag, "_regwrite"}, RegWrite, rw);
      check({tag, "_waddr"}, WriteAddr, a);
      check({tag, "_wdata"}, WriteData, d);
   endtask

   logic        exp_g1;
   logic [15:0] exp_d, prev_d;

   initial begin
      // Reset held two cycles with a pending requester-0 beat
      reset = 1'b1;
      Req0 = 1'b1; Addr0 = 3'd3; Data0 = 16'hAAAA; Last0 = 1'b1;
      Req1 = 1'b0; Addr1 = 3'd0; Data1 = 16'h0000; Last1 = 1'b1;
      cyc(); settle();
      check("rst_gnt0_c1", Gnt0, 0);
      cyc(); settle();
      check("rst_gnt0_c2", Gnt0, 0);
      reset = 1'b0;
      settle();
      wr("post_rst", 0, 3'd0, 16'h0000);
      check("post_rst_gnt0", Gnt0, 1);
      check("post_rst_busy", Busy, 0);
      check("post_rst_state", dbg_state, 0);
      cyc();
      Req0 = 1'b0; settle();
      wr("rst_beat", 1, 3'd3, 16'hAAAA);

      // Single beat
      cyc();
      Req0 = 1'b1; Addr0 = 3'd5; Data0 = 16'h1234; Last0 = 1'b1; settle();
      check("single_gnt0", Gnt0, 1);
      check("single_gnt1", Gnt1, 0);
      cyc();
      Req0 = 1'b0; settle();
      wr("single_n1", 1, 3'd5, 16'h1234);
      cyc(); settle();
      wr("single_n2", 0, 3'd5, 16'h1234);

      // Fresh reset so round-robin starts from Prio=0
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      Req0 = 1'b1; Req1 = 1'b1; Last0 = 1'b1; Last1 = 1'b1;
      Addr0 = 3'd4; Addr1 = 3'd6;
      prev_d = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         Data0 = 16'h0100 + 16'(k);
         Data1 = 16'h0200 + 16'(k);
         settle();
         exp_g1 = (k % 2) == 1;
         exp_d  = exp_g1 ? Data1 : Data0;
         check($sformatf("rr%0d_gnt0", k), Gnt0, !exp_g1);
         check($sformatf("rr%0d_gnt1", k), Gnt1, exp_g1);
         if (k == 0) check("rr0_regwrite", RegWrite, 0);
         else        wr($sformatf("rr%0d", k), 1, exp_g1 ? 3'd4 : 3'd6, prev_d);
         prev_d = exp_d;
         cyc();
      end

      // Burst on requester 1 (Prio now 1) with requester 0 held high, gap of two cycles
      Addr1 = 3'd1; Data1 = 16'hB001; Last1 = 1'b0; settle();
      check("b1_gnt1", Gnt1, 1);
      check("b1_gnt0", Gnt0, 0);
      check("b1_busy", Busy, 0);
      wr("b1", 1, 3'd4, 16'h0104);
      cyc();
      Req1 = 1'b0; settle();
      check("gap1_busy", Busy, 1);
      check("gap1_gnt0", Gnt0, 0);
      check("gap1_gnt1", Gnt1, 0);
      wr("gap1", 1, 3'd1, 16'hB001);
      cyc(); settle();
      check("gap2_busy", Busy, 1);
      check("gap2_gnt0", Gnt0, 0);
      wr("gap2", 0, 3'd1, 16'hB001);
      cyc();
      Req1 = 1'b1; Addr1 = 3'd2; Data1 = 16'hB002; Last1 = 1'b0; settle();
      check("b2_gnt1", Gnt1, 1);
      check("b2_gnt0", Gnt0, 0);
      check("gap3_regwrite", RegWrite, 0);
      cyc();
      Addr1 = 3'd3; Data1 = 16'hB003; Last1 = 1'b1; settle();
      check("b3_gnt1", Gnt1, 1);
      check("b3_gnt0", Gnt0, 0);
      check("b3_busy", Busy, 1);
      wr("b3", 1, 3'd2, 16'hB002);
      cyc();

      // After the burst requester 0 wins; requester 1 now offers an R0 beat
      Addr1 = 3'd0; Data1 = 16'hFFFF; Last1 = 1'b1;
      Addr0 = 3'd4; Data0 = 16'h0C0C; Last0 = 1'b1; settle();
      check("post_burst_gnt0", Gnt0, 1);
      check("post_burst_gnt1", Gnt1, 0);
      check("post_burst_busy", Busy, 0);
      wr("b_end", 1, 3'd3, 16'hB003);
      cyc();
      Req0 = 1'b0; settle();
      check("r0_gnt1", Gnt1, 1);
      wr("pre_r0", 1, 3'd4, 16'h0C0C);
      cyc();
      // R0 write suppressed; Prio back at 0 so requester 0 wins a tie
      Req0 = 1'b1; Addr0 = 3'd5; Data0 = 16'h5555;
      Addr1 = 3'd7; Data1 = 16'h7777; settle();
      wr("r0", 0, 3'd4, 16'h0C0C);
      check("r0_prio_gnt0", Gnt0, 1);
      check("r0_prio_gnt1", Gnt1, 0);
      cyc();

      // Requester 0 burst of 4, reset after the 2nd beat
      Req1 = 1'b0; Addr0 = 3'd1; Data0 = 16'hD001; Last0 = 1'b0; settle();
      check("m1_gnt0", Gnt0, 1);
      wr("m1", 1, 3'd5, 16'h5555);
      cyc();
      Addr0 = 3'd2; Data0 = 16'hD002;
      Req1 = 1'b1; Addr1 = 3'd6; Data1 = 16'h6666; Last1 = 1'b1; settle();
      check("m2_gnt0", Gnt0, 1);
      check("m2_gnt1", Gnt1, 0);
      check("m2_busy", Busy, 1);
      wr("m2", 1, 3'd1, 16'hD001);
      cyc();
      reset = 1'b1; Addr0 = 3'd3; Data0 = 16'hD003; settle();
      check("mrst_gnt0", Gnt0, 0);
      check("mrst_gnt1", Gnt1, 0);
      wr("mrst", 1, 3'd2, 16'hD002);
      cyc();
      reset = 1'b0; Req0 = 1'b0; settle();
      check("after_mrst_busy", Busy, 0);
      check("after_mrst_state", dbg_state, 0);
      check("after_mrst_gnt1", Gnt1, 1);
      wr("after_mrst", 0, 3'd0, 16'h0000);
      cyc();
      Req1 = 1'b0; settle();
      wr("after_mrst_wr", 1, 3'd6, 16'h6666);
      check("final_gnt1", Gnt1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
